// File: rtl/store_checker.sv
// Store checker: compares pipeline data-memory stores against a queue of expected stores.
// Optional macro STORE_CHECKER_FILTER_EN ignores stores whose address differs from the head entry.
module store_checker #(
    parameter int DEPTH = 8,
    parameter int LIMIT = 42
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    input  logic        exp_valid,
    output logic        exp_ready,
    input  logic [31:0] exp_addr,
    input  logic [31:0] exp_data,
    input  logic        exp_last,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic [31:0] err_addr,
    output logic [31:0] err_data,
    output logic [15:0] store_count,
    output logic [15:0] cycle_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {RUN, PASS, FAIL, TIMEOUT} state_t;

    state_t        r_state;
    logic [31:0]   r_fifo_addr [DEPTH];
    logic [31:0]   r_fifo_data [DEPTH];
    logic          r_fifo_last [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_pass;
    logic          r_fail;
    logic          r_timeout;
    logic [31:0]   r_err_addr;
    logic [31:0]   r_err_data;
    logic [15:0]   r_store_count;
    logic [15:0]   r_cycle_count;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_store;
    logic          w_addr_hit;
    logic          w_match;
    logic          w_pop;
    logic          w_fail;

    assign w_full     = (r_count == CW'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign exp_ready  = !w_full;
    assign w_push     = exp_valid && !w_full;
    assign w_store    = memwrite && (r_state == RUN);
    // Comparison always uses the pre-push head, so a same-cycle push never satisfies a store.
    assign w_addr_hit = !w_empty && (dataadr == r_fifo_addr[r_rptr]);
    assign w_match    = w_addr_hit && (writedata == r_fifo_data[r_rptr]);
    assign w_pop      = w_store && w_match;

`ifdef STORE_CHECKER_FILTER_EN
    assign w_fail = w_store && w_addr_hit && !w_match;
`else
    assign w_fail = w_store && !w_match;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_fifo_addr[r_wptr] <= exp_addr;
                r_fifo_data[r_wptr] <= exp_data;
                r_fifo_last[r_wptr] <= exp_last;
                r_wptr              <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Terminal states simply fall through the case, holding every status register until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= RUN;
            r_pass        <= 1'b0;
            r_fail        <= 1'b0;
            r_timeout     <= 1'b0;
            r_err_addr    <= '0;
            r_err_data    <= '0;
            r_store_count <= '0;
            r_cycle_count <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_pop && (r_store_count != 16'hFFFF)) begin
                        r_store_count <= r_store_count + 16'd1;
                    end
                    if (w_fail) begin
                        r_state    <= FAIL;
                        r_fail     <= 1'b1;
                        r_err_addr <= dataadr;
                        r_err_data <= writedata;
                    end else if (w_pop && r_fifo_last[r_rptr]) begin
                        r_state <= PASS;
                        r_pass  <= 1'b1;
                    end else if (!w_store && (r_cycle_count >= 16'(LIMIT))) begin
                        r_state   <= TIMEOUT;
                        r_timeout <= 1'b1;
                    end else begin
                        r_cycle_count <= r_cycle_count + 16'd1;
                    end
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

    assign pass        = r_pass;
    assign fail        = r_fail;
    assign timeout     = r_timeout;
    assign err_addr    = r_err_addr;
    assign err_data    = r_err_data;
    assign store_count = r_store_count;
    assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_store_checker.sv
// Directed self-checking bench for store_checker; expectations follow STORE_CHECKER_FILTER_EN.
module tb_store_checker;

`ifdef STORE_CHECKER_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] dataadr = '0;
    logic [31:0] writedata = '0;
    logic        exp_valid = 1'b0;
    logic        exp_ready;
    logic [31:0] exp_addr = '0;
    logic [31:0] exp_data = '0;
    logic        exp_last = 1'b0;
    logic        pass;
    logic        fail;
    logic        timeout;
    logic [31:0] err_addr;
    logic [31:0] err_data;
    logic [15:0] store_count;
    logic [15:0] cycle_count;

    int nChecks = 0;
    int nFails  = 0;

    store_checker #(.DEPTH(8), .LIMIT(42)) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .exp_valid(exp_valid), .exp_ready(exp_ready),
        .exp_addr(exp_addr), .exp_data(exp_data), .exp_last(exp_last),
        .pass(pass), .fail(fail), .timeout(timeout), .err_addr(err_addr),
        .err_data(err_data), .store_count(store_count), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        reset     = 1'b0;
        memwrite  = 1'b0;
        exp_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
    endtask

    task automatic set_push(input logic [31:0] a, input logic [31:0] d, input logic l);
        exp_valid = 1'b1;
        exp_addr  = a;
        exp_data  = d;
        exp_last  = l;
    endtask

    task automatic set_store(input logic [31:0] a, input logic [31:0] d);
        memwrite  = 1'b1;
        dataadr   = a;
        writedata = d;
    endtask

    task automatic test_reset();
        do_reset();
        nChecks++; if (pass !== 1'b0) begin nFails++; $display("[TB] FAIL reset_pass got %b want 0", pass); end
        nChecks++; if (fail !== 1'b0) begin nFails++; $display("[TB] FAIL reset_fail got %b want 0", fail); end
        nChecks++; if (timeout !== 1'b0) begin nFails++; $display("[TB] FAIL reset_timeout got %b want 0", timeout); end
        nChecks++; if (err_addr !== 32'd0 || err_data !== 32'd0) begin nFails++; $display("[TB] FAIL reset_err got %h/%h want 0/0", err_addr, err_data); end
        nChecks++; if (store_count !== 16'd0 || cycle_count !== 16'd0) begin nFails++; $display("[TB] FAIL reset_counts got %0d/%0d want 0/0", store_count, cycle_count); end
        nChecks++; if (exp_ready !== 1'b1) begin nFails++; $display("[TB] FAIL reset_ready got %b want 1", exp_ready); end
    endtask

    task automatic test_match();
        do_reset();
        set_push(32'd84, 32'hFFFFFFFB, 1'b1); step();
        set_store(32'd84, 32'hFFFFFFFB); step();
        nChecks++; if (pass !== 1'b1 || fail !== 1'b0) begin nFails++; $display("[TB] FAIL match_pass got pass=%b fail=%b want 1/0", pass, fail); end
        nChecks++; if (store_count !== 16'd1) begin nFails++; $display("[TB] FAIL match_count got %0d want 1", store_count); end
        set_store(32'd4, 32'd4); step();
        step();
        nChecks++; if (pass !== 1'b1 || fail !== 1'b0 || store_count !== 16'd1) begin nFails++; $display("[TB] FAIL pass_hold got pass=%b fail=%b cnt=%0d want 1/0/1", pass, fail, store_count); end
    endtask

    task automatic test_mismatch();
        do_reset();
        set_push(32'd84, 32'hFFFFFFFB, 1'b1); step();
        set_store(32'd84, 32'd7); step();
        nChecks++; if (fail !== 1'b1 || pass !== 1'b0) begin nFails++; $display("[TB] FAIL mismatch_fail got fail=%b pass=%b want 1/0", fail, pass); end
        nChecks++; if (err_addr !== 32'd84 || err_data !== 32'd7) begin nFails++; $display("[TB] FAIL mismatch_err got %0d/%0d want 84/7", err_addr, err_data); end
        for (int i = 0; i < 6; i++) begin set_push(32'd200 + i, 32'd0, 1'b0); step(); end
        nChecks++; if (exp_ready !== 1'b1) begin nFails++; $display("[TB] FAIL mismatch_occ7 ready got %b want 1", exp_ready); end
        set_push(32'd300, 32'd0, 1'b0); step();
        nChecks++; if (exp_ready !== 1'b0) begin nFails++; $display("[TB] FAIL mismatch_occ8 ready got %b want 0", exp_ready); end
    endtask

    task automatic test_filter();
        do_reset();
        set_push(32'd80, 32'd1, 1'b0); step();
        set_push(32'd84, 32'd2, 1'b1); step();
        set_store(32'd80, 32'd1); step();
        nChecks++; if (store_count !== 16'd1 || fail !== 1'b0 || pass !== 1'b0) begin nFails++; $display("[TB] FAIL filter_first got cnt=%0d fail=%b pass=%b want 1/0/0", store_count, fail, pass); end
        set_store(32'd88, 32'd5); step();
        if (FILTER) begin
            nChecks++; if (fail !== 1'b0) begin nFails++; $display("[TB] FAIL filter_ignore got fail=%b want 0", fail); end
            set_store(32'd84, 32'd2); step();
            nChecks++; if (pass !== 1'b1 || store_count !== 16'd2) begin nFails++; $display("[TB] FAIL filter_pass got pass=%b cnt=%0d want 1/2", pass, store_count); end
        end else begin
            nChecks++; if (fail !== 1'b1) begin nFails++; $display("[TB] FAIL strict_fail got fail=%b want 1", fail); end
            nChecks++; if (err_addr !== 32'd88 || err_data !== 32'd5) begin nFails++; $display("[TB] FAIL strict_err got %0d/%0d want 88/5", err_addr, err_data); end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        repeat (42) step();
        nChecks++; if (timeout !== 1'b0 || cycle_count !== 16'd42) begin nFails++; $display("[TB] FAIL pre_timeout got to=%b cc=%0d want 0/42", timeout, cycle_count); end
        step();
        nChecks++; if (timeout !== 1'b1 || cycle_count !== 16'd42) begin nFails++; $display("[TB] FAIL timeout got to=%b cc=%0d want 1/42", timeout, cycle_count); end
        repeat (3) step();
        nChecks++; if (timeout !== 1'b1 || cycle_count !== 16'd42) begin nFails++; $display("[TB] FAIL timeout_hold got to=%b cc=%0d want 1/42", timeout, cycle_count); end
        do_reset();
        repeat (42) step();
        set_store(32'd12, 32'd34); step();
        nChecks++; if (timeout !== 1'b0 || fail !== !FILTER) begin nFails++; $display("[TB] FAIL limit_store got to=%b fail=%b want 0/%b", timeout, fail, !FILTER); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 8; i++) begin set_push(32'd100 + 4 * i, i, 1'b0); step(); end
        nChecks++; if (exp_ready !== 1'b0) begin nFails++; $display("[TB] FAIL full_ready got %b want 0", exp_ready); end
        set_push(32'd200, 32'h99, 1'b0); step();
        set_store(32'd100, 32'd0); set_push(32'd300, 32'h77, 1'b0); step();
        nChecks++; if (exp_ready !== 1'b1 || store_count !== 16'd1) begin nFails++; $display("[TB] FAIL full_pop got ready=%b cnt=%0d want 1/1", exp_ready, store_count); end
        for (int i = 1; i < 8; i++) begin set_store(32'd100 + 4 * i, i); step(); end
        nChecks++; if (fail !== 1'b0 || store_count !== 16'd8) begin nFails++; $display("[TB] FAIL full_drain got fail=%b cnt=%0d want 0/8", fail, store_count); end
        set_store(32'd200, 32'h99); step();
        nChecks++; if (store_count !== 16'd8 || fail !== !FILTER) begin nFails++; $display("[TB] FAIL full_refused got cnt=%0d fail=%b want 8/%b", store_count, fail, !FILTER); end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        set_push(32'd40, 32'd1, 1'b0); step();
        set_push(32'd44, 32'd2, 1'b0); step();
        set_push(32'd48, 32'd3, 1'b0); step();
        set_push(32'd52, 32'd4, 1'b0); step();
        set_store(32'd40, 32'd1); step();
        set_store(32'd44, 32'd9); step();
        nChecks++; if (fail !== 1'b1) begin nFails++; $display("[TB] FAIL midrun_fail got %b want 1", fail); end
        reset = 1'b1; set_push(32'd44, 32'd2, 1'b1); set_store(32'd44, 32'd2); step();
        nChecks++; if (fail !== 1'b0 || pass !== 1'b0 || timeout !== 1'b0 || err_addr !== 32'd0 || err_data !== 32'd0) begin nFails++; $display("[TB] FAIL midrun_reset got f=%b p=%b t=%b ea=%h ed=%h want all 0", fail, pass, timeout, err_addr, err_data); end
        nChecks++; if (exp_ready !== 1'b1 || store_count !== 16'd0 || cycle_count !== 16'd0) begin nFails++; $display("[TB] FAIL midrun_ready got ready=%b sc=%0d cc=%0d want 1/0/0", exp_ready, store_count, cycle_count); end
        set_store(32'd44, 32'd2); step();
        nChecks++; if (fail !== !FILTER || store_count !== 16'd0 || pass !== 1'b0) begin nFails++; $display("[TB] FAIL midrun_store got fail=%b sc=%0d pass=%b want %b/0/0", fail, store_count, pass, !FILTER); end
        if (!FILTER) begin
            nChecks++; if (err_addr !== 32'd44 || err_data !== 32'd2) begin nFails++; $display("[TB] FAIL midrun_err got %0d/%0d want 44/2", err_addr, err_data); end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_push(32'd60, 32'd6, 1'b1); set_store(32'd60, 32'd6); step();
        nChecks++; if (fail !== !FILTER || pass !== 1'b0) begin nFails++; $display("[TB] FAIL nobypass got fail=%b pass=%b want %b/0", fail, pass, !FILTER); end
        set_store(32'd60, 32'd6); step();
        nChecks++; if (pass !== FILTER) begin nFails++; $display("[TB] FAIL nobypass_next got pass=%b want %b", pass, FILTER); end
    endtask

    initial begin
        test_reset();
        test_match();
        test_mismatch();
        test_filter();
        test_timeout();
        test_full();
        test_reset_midrun();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
